conv_accum: RTL and testbench

Accumulation stage directly downstream of the `mult_param` multiplier in the convolution datapath. It consumes one `2*WIDTH`-bit unsigned product per `done` pulse and sums `TAPS` products (one kernel window). It then adds a per-window bias and presents the window result on a valid/ready output toward the activation/pooling stage. It provides `prod_ready` back-pressure, which the upstream controller uses to gate the multiplier's `start`.

---
 rtl/conv_accum.sv | 143 ++++++++++++++
 tb/tb_conv_accum.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/conv_accum.sv
// conv_accum: sums TAPS unsigned products per window, adds a per-window bias and
// hands the result downstream on valid/ready. Optional macro CONV_ACCUM_SAT_EN selects saturation.
module conv_accum #(
  parameter int WIDTH     = 8,
  parameter int TAPS      = 9,
  parameter int OUT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2*WIDTH-1:0]   prod,
  input  logic                 prod_valid,
  output logic                 prod_ready,
  input  logic [2*WIDTH-1:0]   bias,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy
);

  localparam int CNT_W = $clog2(TAPS + 1);
  localparam int ACC_W = 2*WIDTH + CNT_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    BIAS = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t               state_r, state_s;
  logic [ACC_W-1:0]     acc_r, acc_s;
  logic [CNT_W-1:0]     cnt_r, cnt_s;
  logic [2*WIDTH-1:0]   bias_r, bias_s;
  logic [OUT_WIDTH-1:0] out_data_r, out_data_s;
  logic                 out_valid_r, out_valid_s;
  logic                 prod_ready_r;
  logic                 busy_r;
  logic                 accept_s;
  logic [ACC_W-1:0]     sum_s;

  // Output formatting: saturate or wrap the window result into OUT_WIDTH bits.
  function automatic logic [OUT_WIDTH-1:0] fmt(input logic [ACC_W-1:0] x);
    logic [OUT_WIDTH-1:0] res;
`ifdef CONV_ACCUM_SAT_EN
    logic [ACC_W-1:0] lim;
    lim = ACC_W'({OUT_WIDTH{1'b1}});
    if (x > lim) begin
      res = {OUT_WIDTH{1'b1}};
    end else begin
      res = x[OUT_WIDTH-1:0];
    end
`else
    res = x[OUT_WIDTH-1:0];
`endif
    return res;
  endfunction

  assign accept_s   = prod_valid & prod_ready_r;
  assign sum_s      = acc_r + ACC_W'(bias_r);
  assign prod_ready = prod_ready_r;
  assign busy       = busy_r;
  assign out_data   = out_data_r;
  assign out_valid  = out_valid_r;

  // Next-state and datapath update for the window sequencer.
  always_comb begin
    state_s     = state_r;
    acc_s       = acc_r;
    cnt_s       = cnt_r;
    bias_s      = bias_r;
    out_data_s  = out_data_r;
    out_valid_s = out_valid_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          acc_s   = ACC_W'(prod);
          bias_s  = bias;
          cnt_s   = CNT_W'(1);
          state_s = (TAPS == 1) ? BIAS : ACC;
        end else begin
          state_s = IDLE;
        end
      end
      ACC: begin
        if (accept_s) begin
          acc_s = acc_r + ACC_W'(prod);
          cnt_s = cnt_r + CNT_W'(1);
          // cnt_r counts products already summed, so TAPS-1 means this is the last one.
          if (cnt_r == CNT_W'(TAPS - 1)) begin
            state_s = BIAS;
          end else begin
            state_s = ACC;
          end
        end else begin
          state_s = ACC;
        end
      end
      BIAS: begin
        acc_s       = sum_s;
        out_data_s  = fmt(sum_s);
        out_valid_s = 1'b1;
        state_s     = OUT;
      end
      OUT: begin
        if (out_ready) begin
          out_valid_s = 1'b0;
          out_data_s  = {OUT_WIDTH{1'b0}};
          cnt_s       = {CNT_W{1'b0}};
          state_s     = IDLE;
        end else begin
          state_s = OUT;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      acc_r        <= {ACC_W{1'b0}};
      cnt_r        <= {CNT_W{1'b0}};
      bias_r       <= {(2*WIDTH){1'b0}};
      out_data_r   <= {OUT_WIDTH{1'b0}};
      out_valid_r  <= 1'b0;
      prod_ready_r <= 1'b1;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      acc_r        <= acc_s;
      cnt_r        <= cnt_s;
      bias_r       <= bias_s;
      out_data_r   <= out_data_s;
      out_valid_r  <= out_valid_s;
      prod_ready_r <= (state_s == IDLE) || (state_s == ACC);
      busy_r       <= (state_s != IDLE);
    end
  end

endmodule

// File: tb/tb_conv_accum.sv
// Directed self-checking bench for conv_accum: a TAPS=9 instance for the main
// scenarios and a TAPS=1 instance for the single-product window.
module tb_conv_accum;

  logic        clk;
  logic        reset;
  logic [15:0] prod, bias, out_data;
  logic        prod_valid, prod_ready, out_valid, out_ready, busy;
  logic [15:0] prod1, bias1, out_data1;
  logic        prod_valid1, prod_ready1, out_valid1, out_ready1, busy1;

  int vectors = 0;
  int errs    = 0;

  conv_accum #(.WIDTH(8), .TAPS(9), .OUT_WIDTH(16)) u_dut (
    .clk(clk), .reset(reset), .prod(prod), .prod_valid(prod_valid),
    .prod_ready(prod_ready), .bias(bias), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  conv_accum #(.WIDTH(8), .TAPS(1), .OUT_WIDTH(16)) u_dut1 (
    .clk(clk), .reset(reset), .prod(prod1), .prod_valid(prod_valid1),
    .prod_ready(prod_ready1), .bias(bias1), .out_data(out_data1),
    .out_valid(out_valid1), .out_ready(out_ready1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [15:0] v);
    prod       = v;
    prod_valid = 1'b1;
    step();
    prod_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; prod = 16'd0; bias = 16'd0; prod_valid = 1'b0; out_ready = 1'b0;
    prod1 = 16'd0; bias1 = 16'd0; prod_valid1 = 1'b0; out_ready1 = 1'b0;
    step(); step();
    reset = 1'b0;

    // reset values
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_prod_ready", 32'(prod_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst1_prod_ready", 32'(prod_ready1), 32'd1);

    // basic window: 1..9 + 10 = 55
    out_ready = 1'b1; bias = 16'd10;
    for (int i = 1; i <= 9; i++) begin
      prod = 16'(i); prod_valid = 1'b1;
      step();
      if (i == 1) chk("basic_busy_first", 32'(busy), 32'd1);
    end
    prod_valid = 1'b0;
    chk("basic_bias_valid", 32'(out_valid), 32'd0);
    chk("basic_bias_ready", 32'(prod_ready), 32'd0);
    step();
    chk("basic_valid", 32'(out_valid), 32'd1);
    chk("basic_data", 32'(out_data), 32'd55);
    step();
    chk("basic_valid_drop", 32'(out_valid), 32'd0);
    chk("basic_data_clr", 32'(out_data), 32'd0);
    chk("basic_busy_after", 32'(busy), 32'd0);
    chk("basic_ready_after", 32'(prod_ready), 32'd1);

    // late bias change: bias sampled with first product only
    bias = 16'd10;
    send(16'd1);
    bias = 16'd500;
    for (int i = 2; i <= 9; i++) send(16'(i));
    step();
    chk("late_bias_data", 32'(out_data), 32'd55);
    step();

    // overflow: 9 * 65025 = 585225
    bias = 16'd0;
    for (int i = 0; i < 9; i++) send(16'd65025);
    step();
    chk("ovf_valid", 32'(out_valid), 32'd1);
`ifdef CONV_ACCUM_SAT_EN
    chk("ovf_data", 32'(out_data), 32'd65535);
`else
    chk("ovf_data", 32'(out_data), 32'd60937);
`endif
    step();

    // gaps and back-pressure: 9 * 100 + 5 = 905
    out_ready = 1'b0; bias = 16'd5;
    for (int i = 0; i < 9; i++) begin
      for (int g = 0; g < (i % 3); g++) step();
      if (i == 4) chk("gap_busy_hold", 32'(busy), 32'd1);
      send(16'd100);
    end
    prod = 16'd77; prod_valid = 1'b1;
    chk("gap_bias_ready", 32'(prod_ready), 32'd0);
    step();
    for (int c = 0; c < 7; c++) begin
      chk("gap_hold_valid", 32'(out_valid), 32'd1);
      chk("gap_hold_data", 32'(out_data), 32'd905);
      chk("gap_hold_ready", 32'(prod_ready), 32'd0);
      step();
    end
    out_ready = 1'b1;
    step();
    prod_valid = 1'b0;
    chk("gap_valid_drop", 32'(out_valid), 32'd0);
    chk("gap_idle_busy", 32'(busy), 32'd0);
    bias = 16'd1;
    for (int i = 0; i < 9; i++) send(16'd3);
    step();
    chk("gap_next_data", 32'(out_data), 32'd28);
    step();

    // reset mid-window, then 9 * 2 = 18
    bias = 16'd40;
    for (int i = 0; i < 4; i++) send(16'd50);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_data", 32'(out_data), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(prod_ready), 32'd1);
    bias = 16'd0;
    for (int i = 0; i < 9; i++) send(16'd2);
    step();
    chk("mid_rst_result", 32'(out_data), 32'd18);
    step();

    // TAPS=1: 300 + 7 = 307
    prod1 = 16'd300; bias1 = 16'd7; prod_valid1 = 1'b1; out_ready1 = 1'b1;
    step();
    prod_valid1 = 1'b0;
    chk("t1_bias_valid", 32'(out_valid1), 32'd0);
    chk("t1_bias_ready", 32'(prod_ready1), 32'd0);
    step();
    chk("t1_valid", 32'(out_valid1), 32'd1);
    chk("t1_data", 32'(out_data1), 32'd307);
    step();
    chk("t1_valid_drop", 32'(out_valid1), 32'd0);
    chk("t1_busy_after", 32'(busy1), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
